// File: rtl/serial_add_sched.sv
// Bit-serial adder shared by two requesters: round-robin accept, one bit per clock
// through a single full-adder cell, registered valid/ready response.
module serial_add_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_cin,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             id;
  logic             last_grant;
  logic             fa_s;
  logic             fa_cout;
  logic             gnt0;
  logic             gnt1;

  // Round-robin: on contention the port that did not win last time is granted.
  assign gnt0     = (state == IDLE) && r0_valid && (!r1_valid || last_grant);
  assign gnt1     = (state == IDLE) && r1_valid && (!r0_valid || !last_grant);
  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  adder_1_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; shift form avoids an empty slice when WIDTH=1.
  assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_sh       <= gnt1 ? r1_a : r0_a;
            b_sh       <= gnt1 ? r1_b : r0_b;
            carry      <= gnt1 ? r1_cin : r0_cin;
            cnt        <= '0;
            id         <= gnt1;
            last_grant <= gnt1;
            state      <= RUN;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_next;
            rsp_cout  <= fa_cout;
            rsp_id    <= id;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// Single full-adder cell.
module adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: scoreboard of expected sums filled at accept,
// drained at response handshake, plus a WIDTH=1 instance.
module tb_serial_add_sched;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0_valid, r0_ready, r0_cin;
  logic [W-1:0] r0_a, r0_b;
  logic         r1_valid, r1_ready, r1_cin;
  logic [W-1:0] r1_a, r1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  logic w1_r0_valid, w1_r0_ready, w1_r0_a, w1_r0_b, w1_r0_cin;
  logic w1_r1_ready;
  logic w1_rsp_valid, w1_rsp_id, w1_rsp_sum, w1_rsp_cout, w1_busy;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  serial_add_sched #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(w1_r0_valid), .r0_ready(w1_r0_ready), .r0_a(w1_r0_a), .r0_b(w1_r0_b),
    .r0_cin(w1_r0_cin),
    .r1_valid(1'b0), .r1_ready(w1_r1_ready), .r1_a(1'b0), .r1_b(1'b0), .r1_cin(1'b0),
    .rsp_valid(w1_rsp_valid), .rsp_ready(1'b1), .rsp_id(w1_rsp_id), .rsp_sum(w1_rsp_sum),
    .rsp_cout(w1_rsp_cout), .busy(w1_busy)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t     sb[$];
  exp_t     e;
  int       grants[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  int       acc_cyc = 0;
  int       hs_cyc = 0;
  int       rsp_cnt = 0;
  logic     prev_v = 1'b0;
  logic [W:0] t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model result at accept, compare at response handshake, protocol checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_v = 1'b0;
    end else begin
      check("one_ready", 64'(r0_ready & r1_ready), 64'd0);
      check("ready_wo_valid", 64'((r0_ready & ~r0_valid) | (r1_ready & ~r1_valid)), 64'd0);
      if (busy) check("ready_when_busy", 64'({r0_ready, r1_ready}), 64'd0);
      if (r0_valid && r0_ready) begin
        t = (W+1)'(r0_a) + (W+1)'(r0_b) + (W+1)'(r0_cin);
        sb.push_back('{id: 1'b0, sum: t[W-1:0], cout: t[W]});
        grants.push_back(0);
        acc_cyc = cyc + 1;
      end
      if (r1_valid && r1_ready) begin
        t = (W+1)'(r1_a) + (W+1)'(r1_b) + (W+1)'(r1_cin);
        sb.push_back('{id: 1'b1, sum: t[W-1:0], cout: t[W]});
        grants.push_back(1);
        acc_cyc = cyc + 1;
      end
      if (rsp_valid && !prev_v) check("latency", 64'(cyc), 64'(acc_cyc + int'(W)));
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        end
        rsp_cnt++;
        hs_cyc = cyc + 1;
      end
      prev_v = rsp_valid;
    end
  end

  task automatic do_req(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    bit got = 0;
    if (port == 0) begin r0_a = a; r0_b = b; r0_cin = cin; r0_valid = 1'b1; end
    else           begin r1_a = a; r1_b = b; r1_cin = cin; r1_valid = 1'b1; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((port == 0) ? r0_ready : r1_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    if (port == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    check("grant_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_cnt < n && k < 200) begin @(posedge clk); k++; end
    #1;
    check("rsp_timeout", 64'(rsp_cnt >= n), 64'd1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    {r0_valid, r0_a, r0_b, r0_cin} = '0;
    {r1_valid, r1_a, r1_b, r1_cin} = '0;
    rsp_ready = 1'b1;
    {w1_r0_valid, w1_r0_a, w1_r0_b, w1_r0_cin} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: FF+01 carries all the way out
    do_req(0, 8'hFF, 8'h01, 1'b0);
    wait_rsp(1);
    // 2: port 1 alone
    do_req(1, 8'h7F, 8'h00, 1'b1);
    wait_rsp(2);

    // 3: both valid continuously, grants alternate
    grants.delete();
    r0_a = 8'h12; r0_b = 8'h34; r0_cin = 1'b0;
    r1_a = 8'hA0; r1_b = 8'h70; r1_cin = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    k = 0;
    while (grants.size() < 4 && k < 200) begin @(posedge clk); #1; k++; end
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("alt_grant_count", 64'(grants.size()), 64'd4);
    if (grants.size() >= 4) begin
      check("alt_grant0", 64'(grants[0]), 64'd0);
      check("alt_grant1", 64'(grants[1]), 64'd1);
      check("alt_grant2", 64'(grants[2]), 64'd0);
      check("alt_grant3", 64'(grants[3]), 64'd1);
    end
    wait_rsp(6);

    // 4: backpressure holds response and blocks new accepts
    rsp_ready = 1'b0;
    do_req(1, 8'hC3, 8'h5A, 1'b1);
    r0_a = 8'h01; r0_b = 8'h02; r0_cin = 1'b0; r0_valid = 1'b1;
    k = 0;
    while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_sum", 64'(rsp_sum), 64'h1E);
      check("bp_cout", 64'(rsp_cout), 64'd1);
      check("bp_id", 64'(rsp_id), 64'd1);
      check("bp_ready", 64'({r0_ready, r1_ready}), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    grants.delete();
    k = 0;
    while (grants.size() < 1 && k < 50) begin @(posedge clk); #1; k++; end
    r0_valid = 1'b0;
    check("bp_next_accept", 64'(acc_cyc), 64'(hs_cyc + 1));
    check("bp_single_hs", 64'(rsp_cnt), 64'd7);
    wait_rsp(8);

    // 5: reset during RUN aborts; port 0 wins afterwards
    do_req(1, 8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(rsp_cnt), 64'd8);
    grants.delete();
    r0_a = 8'h0F; r0_b = 8'h01; r0_cin = 1'b0;
    r1_a = 8'h22; r1_b = 8'h11; r1_cin = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    k = 0;
    while (grants.size() < 1 && k < 50) begin @(posedge clk); #1; k++; end
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("post_rst_grant_n", 64'(grants.size()), 64'd1);
    if (grants.size() >= 1) check("post_rst_grant", 64'(grants[0]), 64'd0);
    wait_rsp(9);

    // 6: operand change after accept has no effect
    do_req(0, 8'h55, 8'h2B, 1'b1);
    r0_a = 8'hAA; r0_b = 8'hFF; r0_cin = 1'b0;
    wait_rsp(10);

    // 6b: WIDTH=1 instance
    w1_r0_a = 1'b1; w1_r0_b = 1'b1; w1_r0_cin = 1'b1; w1_r0_valid = 1'b1;
    #1 check("w1_ready", 64'(w1_r0_ready), 64'd1);
    @(posedge clk); #1 w1_r0_valid = 1'b0;
    check("w1_busy", 64'(w1_busy), 64'd1);
    check("w1_not_yet", 64'(w1_rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("w1_rsp_valid", 64'(w1_rsp_valid), 64'd1);
    check("w1_sum", 64'(w1_rsp_sum), 64'd1);
    check("w1_cout", 64'(w1_rsp_cout), 64'd1);
    check("w1_id", 64'(w1_rsp_id), 64'd0);
    @(posedge clk); #1;
    check("w1_idle", 64'(w1_busy), 64'd0);

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Bit-serial adder scheduler: one adder_1_bit instance is shared between two requesters.
- Each accepted request is processed LSB-first, one bit per clock, through that single full-adder cell.
- The block is the low-area alternative to the ripple-carry chain when throughput is not critical.
- It arbitrates round-robin, sequences the bit loop, and returns the sum with a valid/ready response.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
r0_valid  in  1  requester 0 has operands
r0_ready  out  1  requester 0 accepted this cycle
r0_a  in  WIDTH  requester 0 operand A
r0_b  in  WIDTH  requester 0 operand B
r0_cin  in  1  requester 0 carry-in
r1_valid  in  1  requester 1 has operands
r1_ready  out  1  requester 1 accepted this cycle
r1_a  in  WIDTH  requester 1 operand A
r1_b  in  WIDTH  requester 1 operand B
r1_cin  in  1  requester 1 carry-in
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  index of requester that owns the result
rsp_sum  out  WIDTH  A+B+cin modulo 2^WIDTH
rsp_cout  out  1  carry out of bit WIDTH-1
busy  out  1  high in RUN or RESP

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; rsp_valid, rsp_id, rsp_sum, rsp_cout, busy all 0; last_grant=1, so port 0 wins first; internal shift, carry and counter registers cleared.
- Reset asserted mid-RUN or mid-RESP aborts the operation. The result is discarded and no response is issued.
- FSM states: IDLE, RUN, RESP.

IDLE:
- r0_ready/r1_ready are combinational from state, valids and last_grant, never from rsp_ready.
- Only one requester is valid: that port gets ready=1.
- Both are valid: the port != last_grant gets ready=1; the other gets 0.
- Neither ready is ever high outside IDLE.
- Handshake (valid & ready at an edge) performs, on that same edge:
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0;
  - id and last_grant <= granted port;
  - state<=RUN.

RUN:
- adder_1_bit is fed a_sh[0], b_sh[0], carry.
- Each edge:
  - sum_sh <= {s, sum_sh[WIDTH-1:1]};
  - a_sh and b_sh shift right by 1;
  - carry <= cout;
  - cnt <= cnt+1.
- The edge on which cnt==WIDTH-1 does the last bit and sets state=RESP.
- Latency: rsp_valid rises exactly WIDTH cycles after the accept edge.

RESP:
- rsp_valid=1. rsp_sum=sum_sh, rsp_cout=carry, rsp_id=id.
- All rsp_* outputs are registered and stay stable while rsp_ready=0, however long.
- Handshake (rsp_valid & rsp_ready at an edge): state<=IDLE, rsp_valid<=0.
- No new request is accepted on that edge. Minimum request-to-request period is WIDTH+2 cycles.

General rules:
- Requester inputs are sampled only on the accept edge. Changes afterwards do not affect the in-flight result.
- A requester that drops valid before being granted is simply not served; no state changes.
- cnt is $clog2(WIDTH)+1 bits wide, so WIDTH=1 works: one RUN cycle, then RESP.
- Arithmetic is unsigned. rsp_cout is the true carry out; no overflow flag.
- busy = (state!=IDLE).

Test Plan:
1. WIDTH=8, r0: a=0xFF, b=0x01, cin=0, rsp_ready=1 -> rsp_valid exactly 8 cycles after accept; sum=0x00, cout=1, id=0.
2. r1: a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, id=1; r0_ready stays 0 throughout.
3. Both valid continuously with distinct operands (r0 0x12+0x34 -> 0x46, r1 0xA0+0x70 -> 0x10/cout1):
   - grants alternate 0,1,0,1;
   - rsp_id follows the grants;
   - each response is correct.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid ->
   - rsp_sum, rsp_cout, rsp_id unchanged;
   - r0_ready and r1_ready stay 0;
   - on rsp_ready=1, one handshake, then IDLE, and the next accept follows one cycle later.
5. Reset mid-RUN: pulse rst_n low at cycle 4 of an 8-bit add ->
   - rsp_valid and busy go 0 immediately;
   - no response is issued;
   - the next request is granted to port 0 and computes correctly.
6. Operand change after accept, plus WIDTH=1:
   - Changing r0_a during RUN does not alter the result.
   - WIDTH=1 build, a=1, b=1, cin=1 -> sum=1, cout=1, one cycle after accept.
